// File: rtl/mole_sequencer.sv
// -----------------------------------------------------------------------------
// mole_sequencer
//
// Upstream stage of the hit judge. Walks a game of NUM_ROUNDS moles:
// each round is a blank gap, a mole shown at a pseudo-random grid cell until
// hit or timeout, and a one-cycle round-clear marker. It keeps hit, miss and
// round counts for the score and display stages.
//
// Parameters:
//   SHOW_CYCLES  max cycles a mole is shown (>= 1)
//   GAP_CYCLES   blank cycles before each mole (>= 2, covers the judge hit tail)
//   NUM_ROUNDS   moles per game (1..255)
//   LFSR_SEED    LFSR reset value (0 is replaced by 16'h0001)
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset; aborts a game immediately
//   start      level; sampled only in IDLE/DONE; starts a game
//   hit        latched hit from the judge; sampled only in SHOW
//   pos_0      mole position: 0 = none, 1..9 = grid cell, 11 = round clear
//   busy       high in GAP/SHOW/CLEAR
//   done       high in DONE
//   round_cnt  completed rounds
//   hit_cnt    rounds ended by a hit
//   miss_cnt   rounds ended by timeout
// -----------------------------------------------------------------------------
module mole_sequencer #(
    parameter int unsigned SHOW_CYCLES = 100_000_000,
    parameter int unsigned GAP_CYCLES  = 25_000_000,
    parameter int unsigned NUM_ROUNDS  = 20,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hit,
    output logic [3:0] pos_0,
    output logic       busy,
    output logic       done,
    output logic [7:0] round_cnt,
    output logic [7:0] hit_cnt,
    output logic [7:0] miss_cnt
);

    // An all-zero seed would lock the LFSR up.
    localparam logic [15:0] SeedEff   = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [31:0] GapLast   = 32'(GAP_CYCLES - 1);
    localparam logic [31:0] ShowLast  = 32'(SHOW_CYCLES - 1);
    localparam logic [7:0]  RoundsEnd = 8'(NUM_ROUNDS);
    localparam logic [3:0]  PosNone   = 4'd0;
    localparam logic [3:0]  PosClear  = 4'd11;

    typedef enum logic [2:0] {
        StIdle,
        StGap,
        StShow,
        StClear,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [3:0]  pos_q, pos_d;
    logic [3:0]  prev_pos_q, prev_pos_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [7:0]  round_q, round_d;
    logic [7:0]  hit_q, hit_d;
    logic [7:0]  miss_q, miss_d;
    logic [3:0]  pos_0_q, pos_0_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        lfsr_fb;
    logic [3:0]  cand_base;
    logic [3:0]  cand;
    logic [3:0]  cand_pick;
    logic [7:0]  round_inc;

    // -------------------------------------------------------------------------
    // Position generator
    // -------------------------------------------------------------------------
    // Fibonacci LFSR for x^16 + x^14 + x^13 + x^11 + 1, shifting right; it
    // free-runs every cycle so the pick depends on when each gap ends.
    assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign lfsr_d  = {lfsr_fb, lfsr_q[15:1]};

    // Map the low nibble onto cells 1..9; on a repeat of the previous cell
    // step to the next cell (9 wraps to 1) so consecutive moles always differ.
    assign cand_base = lfsr_q[3:0] % 4'd9;
    assign cand      = cand_base + 4'd1;
    assign cand_pick = (cand != prev_pos_q) ? cand
                     : (cand == 4'd9)       ? 4'd1
                     :                        cand + 4'd1;

    assign round_inc = round_q + 8'd1;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            timer_q    <= 32'd0;
            pos_q      <= PosNone;
            prev_pos_q <= PosNone;
            lfsr_q     <= SeedEff;
            round_q    <= 8'd0;
            hit_q      <= 8'd0;
            miss_q     <= 8'd0;
            pos_0_q    <= PosNone;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            pos_q      <= pos_d;
            prev_pos_q <= prev_pos_d;
            lfsr_q     <= lfsr_d;
            round_q    <= round_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            pos_0_q    <= pos_0_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        pos_d      = pos_q;
        prev_pos_d = prev_pos_q;
        round_d    = round_q;
        hit_d      = hit_q;
        miss_d     = miss_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StGap;
                    timer_d = 32'd0;
                    round_d = 8'd0;
                    hit_d   = 8'd0;
                    miss_d  = 8'd0;
                end
            end

            StGap: begin
                // Any hit level still high from the previous round is ignored here.
                if (timer_q == GapLast) begin
                    state_d    = StShow;
                    timer_d    = 32'd0;
                    pos_d      = cand_pick;
                    prev_pos_d = cand_pick;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end

            StShow: begin
                // A hit on the timeout cycle still counts as a hit.
                if (hit) begin
                    state_d = StClear;
                    hit_d   = hit_q + 8'd1;
                end else if (timer_q == ShowLast) begin
                    state_d = StClear;
                    miss_d  = miss_q + 8'd1;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end

            StClear: begin
                round_d = round_inc;
                if (round_inc == RoundsEnd) begin
                    state_d = StDone;
                end else begin
                    state_d = StGap;
                    timer_d = 32'd0;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic: computed from the next state so the registered outputs
    // line up with the state register.
    // -------------------------------------------------------------------------
    always_comb begin
        pos_0_d = PosNone;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_d)
            StGap: begin
                busy_d = 1'b1;
            end
            StShow: begin
                pos_0_d = pos_d;
                busy_d  = 1'b1;
            end
            StClear: begin
                pos_0_d = PosClear;
                busy_d  = 1'b1;
            end
            StDone: begin
                done_d = 1'b1;
            end
            default: begin
                pos_0_d = PosNone;
            end
        endcase
    end

    assign pos_0     = pos_0_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign round_cnt = round_q;
    assign hit_cnt   = hit_q;
    assign miss_cnt  = miss_q;

endmodule

// File: tb/tb_mole_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mole_sequencer
//
// Directed bench for mole_sequencer with SHOW_CYCLES=8, GAP_CYCLES=4,
// NUM_ROUNDS=3. Inputs change and outputs are sampled on the falling edge.
// A small LFSR model gives the expected mole positions.
// -----------------------------------------------------------------------------
module tb_mole_sequencer;

    localparam int unsigned SHOW   = 8;
    localparam int unsigned GAP    = 4;
    localparam int unsigned ROUNDS = 3;
    localparam logic [15:0] SEED   = 16'hACE1;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       hit   = 1'b0;
    logic [3:0] pos_0;
    logic       busy;
    logic       done;
    logic [7:0] round_cnt;
    logic [7:0] hit_cnt;
    logic [7:0] miss_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_hit;
    int exp_miss;
    int exp_round;
    int game;

    logic [3:0]  m_prev_pos;
    logic [15:0] m_lfsr;
    logic [15:0] m_lfsr_prev;
    logic [3:0]  pos_log [0:1][0:2];

    always #5 clk = ~clk;

    mole_sequencer #(
        .SHOW_CYCLES(SHOW),
        .GAP_CYCLES (GAP),
        .NUM_ROUNDS (ROUNDS),
        .LFSR_SEED  (SEED)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .hit      (hit),
        .pos_0    (pos_0),
        .busy     (busy),
        .done     (done),
        .round_cnt(round_cnt),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    // Reference LFSR: x^16+x^14+x^13+x^11+1, one shift per clock.
    always @(posedge clk) begin
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        m_lfsr_prev <= m_lfsr;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] cand(input logic [15:0] l, input logic [3:0] prev);
        int c;
        c = (int'(l[3:0]) % 9) + 1;
        if (c == int'(prev)) c = (c % 9) + 1;
        return 4'(c);
    endfunction

    task automatic chk_counts(input string tag);
        chk({tag, "_round"}, 32'(round_cnt), exp_round);
        chk({tag, "_hit"},   32'(hit_cnt),   exp_hit);
        chk({tag, "_miss"},  32'(miss_cnt),  exp_miss);
    endtask

    // Reset for three edges, then idle ten cycles with start low.
    task automatic reset_and_idle();
        rst   = 1'b1;
        start = 1'b0;
        hit   = 1'b0;
        repeat (3) @(negedge clk);
        rst        = 1'b0;
        m_prev_pos = 4'd0;
        exp_hit    = 0;
        exp_miss   = 0;
        exp_round  = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_pos",  32'(pos_0), 32'd0);
            chk("idle_busy", 32'(busy),  32'd0);
        end
        chk("idle_done", 32'(done), 32'd0);
        chk_counts("idle");
    endtask

    // One-cycle start pulse; returns in the first GAP cycle.
    task automatic begin_game();
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        exp_hit   = 0;
        exp_miss  = 0;
        exp_round = 0;
        chk("start_busy", 32'(busy),  32'd1);
        chk("start_done", 32'(done),  32'd0);
        chk("start_pos",  32'(pos_0), 32'd0);
        chk_counts("start");
    endtask

    // Entered in GAP cycle 1; returns in the cycle after CLEAR.
    // hit_at: SHOW cycle (1-based) at which hit rises, 0 = never.
    task automatic play_round(input int hit_at, input int rnd);
        logic [3:0] ep;
        int s;
        for (int g = 1; g <= int'(GAP); g++) begin
            if (g > 1) @(negedge clk);
            if (g == 2) hit = 1'b0;  // end of the hit tail from the last round
            chk("gap_pos",  32'(pos_0), 32'd0);
            chk("gap_busy", 32'(busy),  32'd1);
        end
        @(negedge clk);
        ep = cand(m_lfsr_prev, m_prev_pos);
        chk("show_pos_model", 32'(pos_0), 32'(ep));
        chk("show_pos_range", 32'(pos_0 >= 4'd1 && pos_0 <= 4'd9), 32'd1);
        chk("show_no_repeat", 32'(pos_0 != m_prev_pos), 32'd1);
        m_prev_pos          = ep;
        pos_log[game][rnd]  = pos_0;
        s = 1;
        while (1) begin
            if (hit_at != 0 && s >= hit_at) hit = 1'b1;
            if (hit || s == int'(SHOW)) break;
            @(negedge clk);
            s++;
            chk("show_hold", 32'(pos_0), 32'(ep));
        end
        if (hit) exp_hit++;
        else     exp_miss++;
        @(negedge clk);
        chk("clear_pos",  32'(pos_0), 32'd11);
        chk("clear_busy", 32'(busy),  32'd1);
        chk_counts("clear");
        exp_round++;
        @(negedge clk);
        chk_counts("post_clear");
        chk("post_pos", 32'(pos_0), 32'd0);
        if (exp_round == int'(ROUNDS)) begin
            chk("end_done", 32'(done), 32'd1);
            chk("end_busy", 32'(busy), 32'd0);
        end else begin
            chk("next_busy", 32'(busy), 32'd1);
            chk("next_done", 32'(done), 32'd0);
        end
    endtask

    initial begin
        // Reset and idle
        game = 0;
        reset_and_idle();

        // Game 1: miss, hit from SHOW cycle 3, hit on the last SHOW cycle
        begin_game();
        play_round(0, 0);
        play_round(3, 1);
        play_round(8, 2);
        @(negedge clk);
        hit = 1'b0;
        repeat (3) @(negedge clk);
        chk("done_hold_done", 32'(done),  32'd1);
        chk("done_hold_pos",  32'(pos_0), 32'd0);
        chk_counts("done_hold");
        chk("game1_hits", 32'(hit_cnt), 32'd2);

        // Restart from DONE, then reset in the middle of SHOW
        begin_game();
        repeat (GAP) @(negedge clk);
        @(negedge clk);
        chk("mid_show_range", 32'(pos_0 >= 4'd1 && pos_0 <= 4'd9), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_pos",  32'(pos_0), 32'd0);
        chk("abort_busy", 32'(busy),  32'd0);
        chk("abort_done", 32'(done),  32'd0);
        exp_hit   = 0;
        exp_miss  = 0;
        exp_round = 0;
        chk_counts("abort");
        repeat (2) @(negedge clk);
        rst        = 1'b0;
        m_prev_pos = 4'd0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_abort_pos", 32'(pos_0), 32'd0);
        end

        // Game 2: same timing as game 1; start held high during round 2 is ignored
        game = 1;
        begin_game();
        play_round(0, 0);
        start = 1'b1;
        play_round(3, 1);
        chk("start_ignored_miss", 32'(miss_cnt), 32'd1);
        start = 1'b0;
        play_round(8, 2);
        hit = 1'b0;
        for (int r = 0; r < int'(ROUNDS); r++) begin
            chk("seq_repeat", 32'(pos_log[1][r]), 32'(pos_log[0][r]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
